// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared owner-state type and address constants for the data-memory arbiter.
package dmem_arbiter_pkg;
    typedef enum logic [1:0] {FREE, OWN0, OWN1} own_t;
    localparam logic [31:0] PARK_ADDR  = 32'h0;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/response signals of both ports plus the single memory bus.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_rd, mem_wr, mem_accessable;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    modport master (
        output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_accessable,
        input  gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata0, rdata1, mem_rd, mem_wr, mem_addr, mem_wdata
    );
    modport slave (
        input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_accessable,
        output gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata0, rdata1, mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter_pick.sv
// dmem_arb_pick: combinational one-hot winner selection from owner state and requests.
// DMEM_ARB_RR_EN adds the round-robin pointer input; otherwise port 0 wins ties in FREE.
module dmem_arb_pick
    import dmem_arbiter_pkg::*;
(
    input  own_t       i_state,
`ifdef DMEM_ARB_RR_EN
    input  logic       i_ptr,
`endif
    input  logic       i_req0,
    input  logic       i_req1,
    output logic [1:0] o_gnt
);
    logic w_first1;
`ifdef DMEM_ARB_RR_EN
    assign w_first1 = i_ptr & i_req1;
`else
    assign w_first1 = 1'b0;
`endif
    always_comb
        o_gnt = (i_state == OWN0) ? {1'b0, i_req0} :
                (i_state == OWN1) ? {i_req1, 1'b0} :
                w_first1          ? 2'b10 :
                i_req0            ? 2'b01 : {i_req1, 1'b0};
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data-memory arbiter, grant -> issue -> respond pipeline with lock ownership.
// Define DMEM_ARB_RR_EN for round-robin in FREE; default build uses fixed port-0 priority.
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave io_bus
);
    import dmem_arbiter_pkg::*;
    own_t          r_state, w_next;
    logic [1:0]    w_pick, w_gnt, r_rv;
    logic          r_iv, r_ip, r_iwe, r_err;
    logic [AW-1:0] r_iaddr;
    logic [DW-1:0] r_iwdata, r_rdata;
    logic          w_mis, w_iss, w_err;
`ifdef DMEM_ARB_RR_EN
    logic r_ptr;
    always_ff @(posedge clk)
        if (reset) r_ptr <= 1'b0;
        else if (|w_gnt) r_ptr <= w_gnt[0];
`endif
    dmem_arb_pick u_pick (
        .i_state(r_state),
`ifdef DMEM_ARB_RR_EN
        .i_ptr  (r_ptr),
`endif
        .i_req0 (io_bus.req0),
        .i_req1 (io_bus.req1),
        .o_gnt  (w_pick)
    );
    always_ff @(posedge clk)
        r_state <= reset ? FREE : w_next;
    // Any cycle without a grant releases ownership: OWNp always grants p while reqp is high.
    always_comb
        w_next = w_gnt[0] ? (io_bus.lock0 ? OWN0 : FREE) :
                 w_gnt[1] ? (io_bus.lock1 ? OWN1 : FREE) : FREE;
    always_comb begin
        w_gnt       = reset ? 2'b00 : w_pick;
        io_bus.gnt0 = w_gnt[0];
        io_bus.gnt1 = w_gnt[1];
    end
    always_ff @(posedge clk)
        if (reset) begin
            r_iv     <= 1'b0;
            r_ip     <= 1'b0;
            r_iwe    <= 1'b0;
            r_iaddr  <= '0;
            r_iwdata <= '0;
        end else begin
            r_iv     <= |w_gnt;
            r_ip     <= w_gnt[1];
            r_iwe    <= w_gnt[1] ? io_bus.we1 : io_bus.we0;
            r_iaddr  <= w_gnt[1] ? io_bus.addr1 : io_bus.addr0;
            r_iwdata <= w_gnt[1] ? io_bus.wdata1 : io_bus.wdata0;
        end
    assign w_mis = |(r_iaddr[1:0] & ALIGN_MASK);
    assign w_iss = r_iv & ~w_mis;
    assign w_err = w_mis | ~io_bus.mem_accessable;
    assign io_bus.mem_rd    = w_iss & ~r_iwe;
    assign io_bus.mem_wr    = w_iss & r_iwe;
    assign io_bus.mem_addr  = w_iss ? r_iaddr : AW'(PARK_ADDR);
    assign io_bus.mem_wdata = (w_iss & r_iwe) ? r_iwdata : '0;
    always_ff @(posedge clk)
        if (reset) begin
            r_rv    <= 2'b00;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_rv    <= {r_iv & r_ip, r_iv & ~r_ip};
            r_err   <= w_err;
            r_rdata <= (w_err | r_iwe) ? '0 : io_bus.mem_rdata;
        end
    assign io_bus.rvalid0 = r_rv[0];
    assign io_bus.rvalid1 = r_rv[1];
    assign io_bus.rdata0  = r_rv[0] ? r_rdata : '0;
    assign io_bus.rdata1  = r_rv[1] ? r_rdata : '0;
    assign io_bus.err0    = r_rv[0] & r_err;
    assign io_bus.err1    = r_rv[1] & r_err;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven single transactions, directed arbitration/reset sequences, random vs model.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    dmem_arbiter_if bus ();
    dmem_arbiter u_dut (.clk(clk), .reset(reset), .io_bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a == 32'h10010004) ? 32'hDEADBEEF : ({a[15:0], a[31:16]} ^ 32'h5A5A0F0F);
    endfunction
    function automatic logic acc_fn(input logic [31:0] a);
        return a[31:28] != 4'h2;
    endfunction
    assign bus.mem_rdata      = rd_fn(bus.mem_addr);
    assign bus.mem_accessable = acc_fn(bus.mem_addr);

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        e_rd;
        logic        e_wr;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;
    typedef struct {
        logic        v;
        int          p;
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
    } txn_t;
    typedef struct {
        logic        v;
        int          p;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    vec_t        vecs[6];
    txn_t        iss;
    rsp_t        rsp;
    int          own, prio, g;
    logic        pv[2], pwe[2], plk[2], iss_ok;
    logic [31:0] pa[2], pd[2];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic rq, input logic we, input logic lk,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            bus.req0 = rq; bus.we0 = we; bus.lock0 = lk; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = rq; bus.we1 = we; bus.lock1 = lk; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        drive(int'(v.port), 1, v.we, 0, v.addr, v.wdata);
        #1;
        chk("vec_gnt", {bus.gnt1, bus.gnt0}, v.port ? 2'b10 : 2'b01);
        tick();
        drive(int'(v.port), 0, 0, 0, 0, 0);
        #1;
        chk("vec_mem_ctl", {bus.mem_rd, bus.mem_wr}, {v.e_rd, v.e_wr});
        chk("vec_mem_addr", bus.mem_addr, v.e_maddr);
        if (!v.e_rd) chk("vec_mem_wdata", bus.mem_wdata, v.e_mwdata);
        tick();
        chk("vec_rvalid", {bus.rvalid1, bus.rvalid0}, v.port ? 2'b10 : 2'b01);
        chk("vec_rdata", v.port ? bus.rdata1 : bus.rdata0, v.e_rdata);
        chk("vec_err", v.port ? bus.err1 : bus.err0, v.e_err);
        chk("vec_park", {bus.mem_rd, bus.mem_wr, |bus.mem_addr, |bus.mem_wdata}, 0);
        tick();
        chk("vec_rvalid_end", {bus.rvalid1, bus.rvalid0}, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        int k = $urandom_range(0, 9);
        logic [31:0] r = $urandom;
        logic [1:0] m = 2'($urandom_range(1, 3));
        if (k < 6) return {16'h1001, r[15:2], 2'b00};
        if (k < 8) return {4'h2, r[27:2], 2'b00};
        return {16'h1001, r[15:2], m};
    endfunction

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h10010004, 32'h0,        1'b1, 1'b0, 32'h10010004, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h7FFFF000, 32'h12345678, 1'b0, 1'b1, 32'h7FFFF000, 32'h12345678, 32'h0,        1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'h10010002, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b1};
        vecs[3] = '{1'b1, 1'b0, 32'h20000000, 32'h0,        1'b1, 1'b0, 32'h20000000, 32'h0,        32'h0,        1'b1};
        vecs[4] = '{1'b1, 1'b1, 32'h7FFFF001, 32'hAAAA5555, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b1};
        vecs[5] = '{1'b0, 1'b1, 32'h10010008, 32'hCAFEF00D, 1'b0, 1'b1, 32'h10010008, 32'hCAFEF00D, 32'h0,        1'b0};
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 32'h10010004, 0);
        drive(1, 1, 1, 0, 32'h10010008, 32'h1);
        #1;
        chk("rst_gnt", {bus.gnt1, bus.gnt0}, 0);
        chk("rst_rvalid", {bus.rvalid1, bus.rvalid0}, 0);
        chk("rst_rsp", {bus.err1, bus.err0, |bus.rdata1, |bus.rdata0}, 0);
        chk("rst_park", {bus.mem_rd, bus.mem_wr, |bus.mem_addr, |bus.mem_wdata}, 0);
        do_reset();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        do_reset();
        drive(0, 1, 0, 0, 32'h10010010, 0);
        drive(1, 1, 0, 0, 32'h10010020, 0);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("contend_gnt", {bus.gnt1, bus.gnt0}, (RR && (i % 2 == 1)) ? 2'b10 : 2'b01);
            tick();
        end

        do_reset();
        drive(1, 1, 0, 1, 32'h10010030, 0);
        #1;
        chk("lock_gnt_first", {bus.gnt1, bus.gnt0}, 2'b10);
        tick();
        drive(0, 1, 0, 0, 32'h10010040, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lock_gnt_held", {bus.gnt1, bus.gnt0}, 2'b10);
            tick();
        end
        drive(1, 1, 0, 0, 32'h10010030, 0);
        #1;
        chk("lock_gnt_unlock", {bus.gnt1, bus.gnt0}, 2'b10);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        #1;
        chk("lock_gnt_release", {bus.gnt1, bus.gnt0}, 2'b01);
        tick();

        do_reset();
        drive(0, 1, 0, 0, 32'h10010004, 0);
        #1;
        chk("rstmid_gnt", {bus.gnt1, bus.gnt0}, 2'b01);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid_rvalid", {bus.rvalid1, bus.rvalid0}, 0);
        chk("rstmid_rsp", {bus.err1, bus.err0, |bus.rdata1, |bus.rdata0}, 0);
        chk("rstmid_park", {bus.mem_rd, bus.mem_wr, |bus.mem_addr, |bus.mem_wdata}, 0);
        tick();
        chk("rstmid_rvalid_late", {bus.rvalid1, bus.rvalid0}, 0);
        run_vec(vecs[0]);

        do_reset();
        own = -1;
        prio = 0;
        iss.v = 1'b0;
        rsp.v = 1'b0;
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++)
                if (!pv[p] && $urandom_range(0, 99) < 55) begin
                    pv[p]  = 1'b1;
                    pwe[p] = 1'($urandom_range(0, 1));
                    plk[p] = ($urandom_range(0, 3) == 0);
                    pa[p]  = rand_addr();
                    pd[p]  = $urandom;
                end
            drive(0, pv[0], pwe[0], plk[0], pa[0], pd[0]);
            drive(1, pv[1], pwe[1], plk[1], pa[1], pd[1]);
            if (own >= 0)            g = pv[own] ? own : -1;
            else if (pv[0] && pv[1]) g = RR ? prio : 0;
            else                     g = pv[0] ? 0 : (pv[1] ? 1 : -1);
            #1;
            chk("rnd_gnt", {bus.gnt1, bus.gnt0}, (g == 1) ? 2'b10 : (g == 0) ? 2'b01 : 2'b00);
            iss_ok = iss.v && (iss.a[1:0] == 2'b00);
            chk("rnd_mem_ctl", {bus.mem_rd, bus.mem_wr}, iss_ok ? (iss.we ? 2'b01 : 2'b10) : 2'b00);
            chk("rnd_mem_addr", bus.mem_addr, iss_ok ? iss.a : 32'h0);
            if (!iss_ok || iss.we) chk("rnd_mem_wdata", bus.mem_wdata, iss_ok ? iss.d : 32'h0);
            chk("rnd_rvalid", {bus.rvalid1, bus.rvalid0}, rsp.v ? ((rsp.p == 1) ? 2'b10 : 2'b01) : 2'b00);
            if (rsp.v) begin
                chk("rnd_rdata", (rsp.p == 1) ? bus.rdata1 : bus.rdata0, rsp.rdata);
                chk("rnd_err", (rsp.p == 1) ? bus.err1 : bus.err0, rsp.err);
            end
            rsp.v     = iss.v;
            rsp.p     = iss.p;
            rsp.err   = (iss.a[1:0] != 2'b00) || !acc_fn(iss.a);
            rsp.rdata = (rsp.err || iss.we) ? 32'h0 : rd_fn(iss.a);
            iss.v     = (g >= 0);
            if (g >= 0) begin
                iss.p  = g;
                iss.we = pwe[g];
                iss.a  = pa[g];
                iss.d  = pd[g];
                own    = plk[g] ? g : -1;
                prio   = 1 - g;
                pv[g]  = 1'b0;
            end else begin
                own = -1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
